// File: rtl/conv_result_collector16.sv
// Result collector behind the fp16 3x3 MAC PE: bias add, optional ReLU, address tagging,
// show-ahead result FIFO with valid/ready drain, frame tracking and sticky overflow.
module conv_result_collector16 #(
  parameter int data_width = 16,
  parameter int out_height = 26,
  parameter int out_width  = 26,
  parameter int fifo_depth = 4,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [data_width-1:0] pe_result,
  input  logic                  pe_valid,
  input  logic [data_width-1:0] bias,
  input  logic                  relu_en,
  output logic [data_width-1:0] out_data,
  output logic [addr_width-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int ptr_w    = $clog2(fifo_depth);
  localparam int cnt_w    = ptr_w + 1;
  localparam int row_w    = (out_height > 1) ? $clog2(out_height) : 1;
  localparam int col_w    = (out_width > 1) ? $clog2(out_width) : 1;
  localparam int total_px = out_height * out_width;
  localparam int pix_w    = (total_px > 1) ? $clog2(total_px) : 1;
  localparam int entry_w  = data_width + addr_width;

  // fp16 adder shared with the PE: 3 guard bits, round-to-nearest-even, subnormals kept
  function automatic logic [15:0] float_add16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic [4:0]  shift;
    logic [13:0] mx;
    logic [13:0] my;
    logic        sticky;
    logic [14:0] sum;
    logic [5:0]  exp_r;
    logic [14:0] packed_r;
    logic        round_up;
    logic [15:0] res;
    res = 16'h0000;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[14:10];
    ey = y[14:10];
    if (ex == 5'd31) begin
      if (x[9:0] != 10'd0) begin
        res = x | 16'h0200;
      end else if ((ey == 5'd31) && (x[15] != y[15])) begin
        res = 16'h7E00;
      end else begin
        res = x;
      end
    end else begin
      mx     = {(ex != 5'd0), x[9:0], 3'b000};
      my     = {(ey != 5'd0), y[9:0], 3'b000};
      shift  = ((ex == 5'd0) ? 5'd1 : ex) - ((ey == 5'd0) ? 5'd1 : ey);
      sticky = 1'b0;
      for (int i = 0; i < 14; i++) begin
        if (int'(shift) > i) begin
          sticky = sticky | my[0];
          my     = my >> 1;
        end else begin
          my = my;
        end
      end
      my = {my[13:1], my[0] | sticky};
      if (x[15] == y[15]) begin
        sum = {1'b0, mx} + {1'b0, my};
      end else begin
        sum = {1'b0, mx} - {1'b0, my};
      end
      if (sum == 15'd0) begin
        res = (x[15] & y[15]) ? 16'h8000 : 16'h0000;
      end else begin
        exp_r = {1'b0, ((ex == 5'd0) ? 5'd1 : ex)};
        if (sum[14]) begin
          sum   = {1'b0, sum[14:2], sum[1] | sum[0]};
          exp_r = exp_r + 6'd1;
        end else begin
          sum = sum;
        end
        for (int i = 0; i < 13; i++) begin
          if (!sum[13] && (exp_r > 6'd1)) begin
            sum   = sum << 1;
            exp_r = exp_r - 6'd1;
          end else begin
            sum = sum;
          end
        end
        if (!sum[13]) begin
          exp_r = 6'd0;
        end else begin
          exp_r = exp_r;
        end
        if (exp_r >= 6'd31) begin
          res = {x[15], 15'h7C00};
        end else begin
          // rounding carry ripples into the exponent field, which also yields Inf on overflow
          round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
          packed_r = {exp_r[4:0], sum[12:3]} + {14'd0, round_up};
          res      = {x[15], packed_r};
        end
      end
    end
    return res;
  endfunction

  logic [data_width-1:0] s1_data_r;
  logic                  s1_relu_r;
  logic                  s1_vld_r;
  logic [row_w-1:0]      row_r;
  logic [col_w-1:0]      col_r;
  logic [pix_w-1:0]      rd_cnt_r;
  logic [entry_w-1:0]    mem_r [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr_r;
  logic [ptr_w-1:0]      rd_ptr_r;
  logic [cnt_w-1:0]      count_r;
  logic [data_width-1:0] out_data_r;
  logic [addr_width-1:0] out_addr_r;
  logic                  out_valid_r;
  logic                  frame_done_r;
  logic                  overflow_r;

  logic                  pop_s;
  logic                  full_s;
  logic                  wr_s;
  logic                  drop_s;
  logic [data_width-1:0] wdata_s;
  logic [addr_width-1:0] waddr_s;
  logic [cnt_w-1:0]      count_n_s;
  logic [ptr_w-1:0]      rd_ptr_n_s;
  logic [entry_w-1:0]    head_n_s;

  // FIFO control and next head value, so outputs can be registered yet stay show-ahead
  always_comb begin
    pop_s      = out_valid_r & out_ready;
    full_s     = (count_r == cnt_w'(fifo_depth));
    wr_s       = s1_vld_r & (~full_s | pop_s);
    drop_s     = s1_vld_r & full_s & ~pop_s;
    wdata_s    = (s1_relu_r & s1_data_r[data_width-1]) ? {data_width{1'b0}} : s1_data_r;
    waddr_s    = addr_width'(row_r) * addr_width'(out_width) + addr_width'(col_r);
    count_n_s  = count_r + cnt_w'(wr_s) - cnt_w'(pop_s);
    rd_ptr_n_s = rd_ptr_r + ptr_w'(pop_s);
    if (count_n_s == {cnt_w{1'b0}}) begin
      head_n_s = {out_data_r, out_addr_r};
    end else if (wr_s && ((count_r - cnt_w'(pop_s)) == {cnt_w{1'b0}})) begin
      head_n_s = {wdata_s, waddr_s};
    end else begin
      head_n_s = mem_r[rd_ptr_n_s];
    end
  end

  // Stage 1: bias add and ReLU-enable capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_data_r <= {data_width{1'b0}};
      s1_relu_r <= 1'b0;
      s1_vld_r  <= 1'b0;
    end else if (frame_start) begin
      s1_vld_r <= 1'b0;
    end else if (pe_valid) begin
      s1_data_r <= float_add16(pe_result, bias);
      s1_relu_r <= relu_en;
      s1_vld_r  <= 1'b1;
    end else begin
      s1_vld_r <= 1'b0;
    end
  end

  // Write-side pixel position; advances even when the result is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_r <= {row_w{1'b0}};
      col_r <= {col_w{1'b0}};
    end else if (frame_start) begin
      row_r <= {row_w{1'b0}};
      col_r <= {col_w{1'b0}};
    end else if (s1_vld_r) begin
      if (col_r == col_w'(out_width - 1)) begin
        col_r <= {col_w{1'b0}};
        row_r <= (row_r == row_w'(out_height - 1)) ? {row_w{1'b0}} : row_r + row_w'(1);
      end else begin
        col_r <= col_r + col_w'(1);
      end
    end else begin
      col_r <= col_r;
    end
  end

  // FIFO storage, pointers, registered head and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < fifo_depth; i++) mem_r[i] <= {entry_w{1'b0}};
      wr_ptr_r    <= {ptr_w{1'b0}};
      rd_ptr_r    <= {ptr_w{1'b0}};
      count_r     <= {cnt_w{1'b0}};
      out_data_r  <= {data_width{1'b0}};
      out_addr_r  <= {addr_width{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_r    <= {ptr_w{1'b0}};
      rd_ptr_r    <= {ptr_w{1'b0}};
      count_r     <= {cnt_w{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= {wdata_s, waddr_s};
        wr_ptr_r        <= wr_ptr_r + ptr_w'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_n_s;
      count_r     <= count_n_s;
      out_valid_r <= (count_n_s != {cnt_w{1'b0}});
      out_data_r  <= head_n_s[entry_w-1:addr_width];
      out_addr_r  <= head_n_s[addr_width-1:0];
      overflow_r  <= overflow_r | drop_s;
    end
  end

  // Read-side count of accepted pixels drives the end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_r     <= {pix_w{1'b0}};
      frame_done_r <= 1'b0;
    end else if (frame_start) begin
      rd_cnt_r     <= {pix_w{1'b0}};
      frame_done_r <= 1'b0;
    end else if (pop_s) begin
      if (rd_cnt_r == pix_w'(total_px - 1)) begin
        rd_cnt_r     <= {pix_w{1'b0}};
        frame_done_r <= 1'b1;
      end else begin
        rd_cnt_r     <= rd_cnt_r + pix_w'(1);
        frame_done_r <= 1'b0;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign out_data   = out_data_r;
  assign out_addr   = out_addr_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule
